// File: rtl/decode_pkg.sv
// Shared constants, field layout and decode helper for the decode/register-file stage.
package decode_pkg;

    localparam int INSTR_W = 32;
    localparam int OPC_W   = 7;
    localparam int RIDX_W  = 5;
    localparam int NREGS   = 32;
    localparam int OFF_W   = 10;

    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 25;
    localparam int DST_MSB  = 24;
    localparam int DST_LSB  = 20;
    localparam int SRC1_MSB = 19;
    localparam int SRC1_LSB = 15;
    localparam int SRC2_MSB = 14;
    localparam int SRC2_LSB = 10;
    localparam int OFF_MSB  = 9;
    localparam int OFF_LSB  = 0;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [RIDX_W-1:0] dst;
        logic [RIDX_W-1:0] src1;
        logic [RIDX_W-1:0] src2;
        logic [OFF_W-1:0]  offsetlo;
    } instr_t;

    function automatic instr_t splitInstr(input logic [INSTR_W-1:0] word);
        instr_t f;
        f.opcode   = word[OPC_MSB:OPC_LSB];
        f.dst      = word[DST_MSB:DST_LSB];
        f.src1     = word[SRC1_MSB:SRC1_LSB];
        f.src2     = word[SRC2_MSB:SRC2_LSB];
        f.offsetlo = word[OFF_MSB:OFF_LSB];
        return f;
    endfunction

endpackage

// File: rtl/decode_regfile_stage_if.sv
// Fetch-side, execute-side and write-back signals of the decode stage; slave = stage, master = environment.
interface decode_regfile_stage_if
    import decode_pkg::*;
#(
    parameter int XLEN = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [INSTR_W-1:0]  in_instr;
    logic                out_valid;
    logic                out_ready;
    logic [OPC_W-1:0]    opcode;
    logic [RIDX_W-1:0]   dst;
    logic [XLEN-1:0]     src1;
    logic [XLEN-1:0]     src2;
    logic [OFF_W-1:0]    offsetlo;
    logic                wb_en;
    logic [RIDX_W-1:0]   wb_addr;
    logic [XLEN-1:0]     wb_data;

    modport slave (
        input  in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
        output in_ready, out_valid, opcode, dst, src1, src2, offsetlo
    );

    modport master (
        output in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
        input  in_ready, out_valid, opcode, dst, src1, src2, offsetlo
    );
endinterface

// File: rtl/regfile_2r1w.sv
// Register file with two asynchronous read ports and one write port; resets to INIT_BASE+i.
module regfile_2r1w
    import decode_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int INIT_BASE = 10,
    parameter int ZERO_R0   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RIDX_W-1:0] i_raddr1,
    input  logic [RIDX_W-1:0] i_raddr2,
    output logic [XLEN-1:0]   o_rdata1,
    output logic [XLEN-1:0]   o_rdata2,
    input  logic              i_wen,
    input  logic [RIDX_W-1:0] i_waddr,
    input  logic [XLEN-1:0]   i_wdata
);
    logic [XLEN-1:0] r_mem [NREGS];
    logic            w_r0Hard;

    assign w_r0Hard = (ZERO_R0 != 0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= (w_r0Hard && i == 0) ? '0 : XLEN'(INIT_BASE + i);
            end
        end else if (i_wen && !(w_r0Hard && i_waddr == '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (w_r0Hard && i_raddr1 == '0) ? '0 : r_mem[i_raddr1];
    assign o_rdata2 = (w_r0Hard && i_raddr2 == '0) ? '0 : r_mem[i_raddr2];
endmodule

// File: rtl/decode_regfile_stage.sv
// Decode stage: operand read, busy-bit scoreboard, valid/ready handshakes and output register.
// Optional write-back forwarding into the operand read is enabled by defining WB_BYPASS_EN.
module decode_regfile_stage
    import decode_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int INIT_BASE = 10,
    parameter int ZERO_R0   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    decode_regfile_stage_if.slave bus
);
    instr_t            w_fields;
    logic [XLEN-1:0]   w_rf1;
    logic [XLEN-1:0]   w_rf2;
    logic [XLEN-1:0]   w_src1Val;
    logic [XLEN-1:0]   w_src2Val;
    logic              w_r0Hard;
    logic              w_wbEff;
    logic              w_byp1;
    logic              w_byp2;
    logic              w_busy1;
    logic              w_busy2;
    logic              w_busyD;
    logic              w_hazard;
    logic              w_inReady;
    logic              w_issue;
    logic [NREGS-1:0]  w_busyNext;

    logic [NREGS-1:0]  r_busy;
    logic              r_outValid;
    logic [OPC_W-1:0]  r_opcode;
    logic [RIDX_W-1:0] r_dst;
    logic [XLEN-1:0]   r_src1;
    logic [XLEN-1:0]   r_src2;
    logic [OFF_W-1:0]  r_offsetlo;

    assign w_fields = splitInstr(bus.in_instr);
    assign w_r0Hard = (ZERO_R0 != 0);
    assign w_wbEff  = bus.wb_en && !(w_r0Hard && bus.wb_addr == '0);

    regfile_2r1w #(
        .XLEN      (XLEN),
        .INIT_BASE (INIT_BASE),
        .ZERO_R0   (ZERO_R0)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .i_raddr1 (w_fields.src1),
        .i_raddr2 (w_fields.src2),
        .o_rdata1 (w_rf1),
        .o_rdata2 (w_rf2),
        .i_wen    (w_wbEff),
        .i_waddr  (bus.wb_addr),
        .i_wdata  (bus.wb_data)
    );

`ifdef WB_BYPASS_EN
    // A dropped write to a hardwired r0 must not be forwarded either, hence w_wbEff.
    assign w_byp1 = w_wbEff && (bus.wb_addr == w_fields.src1);
    assign w_byp2 = w_wbEff && (bus.wb_addr == w_fields.src2);
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    assign w_src1Val = w_byp1 ? bus.wb_data : w_rf1;
    assign w_src2Val = w_byp2 ? bus.wb_data : w_rf2;

    assign w_busy1   = r_busy[w_fields.src1] && !(w_r0Hard && w_fields.src1 == '0) && !w_byp1;
    assign w_busy2   = r_busy[w_fields.src2] && !(w_r0Hard && w_fields.src2 == '0) && !w_byp2;
    assign w_busyD   = r_busy[w_fields.dst]  && !(w_r0Hard && w_fields.dst  == '0);
    assign w_hazard  = w_busy1 || w_busy2 || w_busyD;
    assign w_inReady = (!r_outValid || bus.out_ready) && !w_hazard;
    assign w_issue   = bus.in_valid && w_inReady;

    // Write-back clears first so that a same-edge issue to that register leaves it busy.
    always_comb begin
        w_busyNext = r_busy;
        if (bus.wb_en) begin
            w_busyNext[bus.wb_addr] = 1'b0;
        end
        if (w_issue && !(w_r0Hard && w_fields.dst == '0)) begin
            w_busyNext[w_fields.dst] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= '0;
            r_outValid <= 1'b0;
            r_opcode   <= '0;
            r_dst      <= '0;
            r_src1     <= '0;
            r_src2     <= '0;
            r_offsetlo <= '0;
        end else begin
            r_busy <= w_busyNext;
            if (w_issue) begin
                r_outValid <= 1'b1;
                r_opcode   <= w_fields.opcode;
                r_dst      <= w_fields.dst;
                r_src1     <= w_src1Val;
                r_src2     <= w_src2Val;
                r_offsetlo <= w_fields.offsetlo;
            end else if (bus.out_ready) begin
                r_outValid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = r_outValid;
    assign bus.opcode    = r_opcode;
    assign bus.dst       = r_dst;
    assign bus.src1      = r_src1;
    assign bus.src2      = r_src2;
    assign bus.offsetlo  = r_offsetlo;
endmodule

// File: tb/tb_decode_regfile_stage.sv
// Self-checking bench for decode_regfile_stage: array/scoreboard model plus directed literal checks.
// Works with or without WB_BYPASS_EN defined; a second instance covers the hardwired-r0 variant.
module tb_decode_regfile_stage;
    import decode_pkg::*;

    localparam int XLEN      = 32;
    localparam int INIT_BASE = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_regfile_stage_if #(.XLEN(XLEN)) dif ();
    decode_regfile_stage_if #(.XLEN(XLEN)) zif ();

    decode_regfile_stage #(.XLEN(XLEN), .INIT_BASE(INIT_BASE), .ZERO_R0(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    decode_regfile_stage #(.XLEN(XLEN), .INIT_BASE(INIT_BASE), .ZERO_R0(1)) dutZ (
        .clk (clk),
        .rst (rst),
        .bus (zif)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model of the ZERO_R0=0 instance: register array, busy flags, held bundle.
    logic [XLEN-1:0] mRegs [NREGS];
    bit              mBusy [NREGS];
    bit              mOutValid;
    logic [6:0]      mOpc;
    logic [4:0]      mDst;
    logic [XLEN-1:0] mSrc1;
    logic [XLEN-1:0] mSrc2;
    logic [9:0]      mOff;

    function automatic bit bypassHits(input int idx);
`ifdef WB_BYPASS_EN
        return dif.wb_en && (int'(dif.wb_addr) == idx);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [XLEN-1:0] readOperand(input int idx);
        if (bypassHits(idx)) return dif.wb_data;
        return mRegs[idx];
    endfunction

    function automatic bit modelReady();
        int  s1, s2, d;
        bit  blocked;
        s1 = int'(dif.in_instr[19:15]);
        s2 = int'(dif.in_instr[14:10]);
        d  = int'(dif.in_instr[24:20]);
        blocked = (mBusy[s1] && !bypassHits(s1)) || (mBusy[s2] && !bypassHits(s2)) || mBusy[d];
        return (!mOutValid || dif.out_ready) && !blocked;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mRegs[i] = XLEN'(INIT_BASE + i);
                mBusy[i] = 1'b0;
            end
            mOutValid = 1'b0;
            mOpc = '0; mDst = '0; mSrc1 = '0; mSrc2 = '0; mOff = '0;
        end else begin
            bit fire;
            fire = dif.in_valid && modelReady();
            if (fire) begin
                mOutValid = 1'b1;
                mOpc  = dif.in_instr[31:25];
                mDst  = dif.in_instr[24:20];
                mSrc1 = readOperand(int'(dif.in_instr[19:15]));
                mSrc2 = readOperand(int'(dif.in_instr[14:10]));
                mOff  = dif.in_instr[9:0];
            end else if (dif.out_ready) begin
                mOutValid = 1'b0;
            end
            if (dif.wb_en) begin
                mRegs[dif.wb_addr] = dif.wb_data;
                mBusy[dif.wb_addr] = 1'b0;
            end
            if (fire) mBusy[dif.in_instr[24:20]] = 1'b1;
        end
    end

    // Compare every cycle on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("out_valid in reset", dif.out_valid, 0);
        end else begin
            checkOutput("model in_ready",  dif.in_ready,  modelReady());
            checkOutput("model out_valid", dif.out_valid, mOutValid);
            checkOutput("model opcode",    dif.opcode,    mOpc);
            checkOutput("model dst",       dif.dst,       mDst);
            checkOutput("model src1",      dif.src1,      mSrc1);
            checkOutput("model src2",      dif.src2,      mSrc2);
            checkOutput("model offsetlo",  dif.offsetlo,  mOff);
        end
    end

    function automatic logic [31:0] mkInstr(input int opc, input int d, input int s1, input int s2, input int off);
        logic [31:0] w;
        w = {7'(opc), 5'(d), 5'(s1), 5'(s2), 10'(off)};
        return w;
    endfunction

    task automatic applyStimulus(input bit v, input logic [31:0] instr, input bit ordy,
                                 input bit we, input int wa, input logic [31:0] wd);
        dif.in_valid  = v;
        dif.in_instr  = instr;
        dif.out_ready = ordy;
        dif.wb_en     = we;
        dif.wb_addr   = 5'(wa);
        dif.wb_data   = wd;
    endtask

    task automatic applyZ(input bit v, input logic [31:0] instr, input bit we, input int wa, input logic [31:0] wd);
        zif.in_valid  = v;
        zif.in_instr  = instr;
        zif.out_ready = 1'b1;
        zif.wb_en     = we;
        zif.wb_addr   = 5'(wa);
        zif.wb_data   = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        testsFailed++;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        logic [31:0] instrB, instrD, instrF, instrH;
        applyStimulus(0, 32'h0, 1, 0, 0, 32'h0);
        applyZ(0, 32'h0, 0, 0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and first issue: reg3=13, reg31=41.
        @(negedge clk);
        checkOutput("reset out_valid", dif.out_valid, 0);
        checkOutput("reset in_ready",  dif.in_ready,  1);
        checkOutput("reset src1",      dif.src1,      0);
        tick(); applyStimulus(1, mkInstr(7'h11, 1, 3, 31, 10'h2A), 1, 0, 0, 0);
        @(negedge clk);
        tick(); applyStimulus(0, 32'h0, 1, 0, 0, 0);
        @(negedge clk);
        checkOutput("first out_valid", dif.out_valid, 1);
        checkOutput("first src1",      dif.src1,      13);
        checkOutput("first src2",      dif.src2,      41);
        checkOutput("first opcode",    dif.opcode,    7'h11);
        checkOutput("first offsetlo",  dif.offsetlo,  10'h2A);

        // Hardwired r0 instance: writes to r0 dropped, r0 never busy, never forwarded.
        tick(); applyZ(0, 32'h0, 1, 0, 32'hFFFF);
        @(negedge clk);
        tick(); applyZ(1, mkInstr(2, 0, 3, 0, 0), 0, 0, 0);
        @(negedge clk);
        checkOutput("zr0 in_ready dst0", zif.in_ready, 1);
        tick(); applyZ(1, mkInstr(3, 4, 0, 0, 0), 0, 0, 0);
        @(negedge clk);
        checkOutput("zr0 in_ready src0",  zif.in_ready,  1);
        checkOutput("zr0 dst",            zif.dst,       0);
        checkOutput("zr0 src1 reg3",      zif.src1,      13);
        checkOutput("zr0 src2 reg0",      zif.src2,      0);
        tick(); applyZ(1, mkInstr(4, 5, 0, 0, 0), 1, 0, 32'hFFFF);
        @(negedge clk);
        checkOutput("zr0 in_ready wb0",   zif.in_ready,  1);
        checkOutput("zr0 src1 after wb",  zif.src1,      0);
        tick(); applyZ(0, 32'h0, 0, 0, 0);
        @(negedge clk);
        checkOutput("zr0 src1 wb0 same", zif.src1,     0);
        checkOutput("zr0 opcode",        zif.opcode,   4);

        // RAW on r5 resolved by write-back of 0x55.
        instrB = mkInstr(7'h22, 8, 5, 6, 10'h20);
        tick(); applyStimulus(1, mkInstr(7'h21, 5, 2, 4, 10'h10), 1, 0, 0, 0);
        @(negedge clk);
        tick(); applyStimulus(1, instrB, 1, 0, 0, 0);
        @(negedge clk);
        checkOutput("RAW stall 1", dif.in_ready, 0);
        tick();
        @(negedge clk);
        checkOutput("RAW stall 2", dif.in_ready, 0);
        tick(); applyStimulus(1, instrB, 1, 1, 5, 32'h55);
`ifdef WB_BYPASS_EN
        @(negedge clk);
        checkOutput("RAW bypass ready", dif.in_ready, 1);
        tick(); applyStimulus(0, instrB, 1, 0, 0, 0);
`else
        @(negedge clk);
        checkOutput("RAW wb-cycle stall", dif.in_ready, 0);
        tick(); applyStimulus(1, instrB, 1, 0, 0, 0);
        @(negedge clk);
        checkOutput("RAW ready after wb", dif.in_ready, 1);
        tick(); applyStimulus(0, instrB, 1, 0, 0, 0);
`endif
        @(negedge clk);
        checkOutput("RAW out_valid", dif.out_valid, 1);
        checkOutput("RAW src1",      dif.src1,      32'h55);
        checkOutput("RAW src2",      dif.src2,      16);
        checkOutput("RAW dst",       dif.dst,       8);

        // Backpressure: bundle C held three cycles while D waits.
        instrD = mkInstr(7'h32, 12, 13, 14, 10'h4);
        tick(); applyStimulus(1, mkInstr(7'h31, 9, 10, 11, 10'h3), 1, 0, 0, 0);
        @(negedge clk);
        tick(); applyStimulus(1, instrD, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bp in_ready", dif.in_ready, 0);
            checkOutput("bp held dst", dif.dst,      9);
            checkOutput("bp held src1", dif.src1,    20);
            tick();
        end
        applyStimulus(1, instrD, 1, 0, 0, 0);
        @(negedge clk);
        checkOutput("bp release ready", dif.in_ready, 1);
        tick(); applyStimulus(0, instrD, 1, 0, 0, 0);
        @(negedge clk);
        checkOutput("bp D dst",  dif.dst,  12);
        checkOutput("bp D src1", dif.src1, 23);
        checkOutput("bp D src2", dif.src2, 24);
        tick();
        @(negedge clk);
        checkOutput("bp no duplicate", dif.out_valid, 0);

        // Same-edge set/clear on r7: the set wins, so r7 stays busy.
        instrF = mkInstr(7'h42, 15, 7, 2, 0);
        tick(); applyStimulus(1, mkInstr(7'h41, 7, 2, 3, 0), 1, 1, 7, 32'h77);
        @(negedge clk);
        tick(); applyStimulus(1, instrF, 1, 0, 0, 0);
        @(negedge clk);
        checkOutput("setwins stall 1", dif.in_ready, 0);
        tick();
        @(negedge clk);
        checkOutput("setwins stall 2", dif.in_ready, 0);
        tick(); applyStimulus(1, instrF, 1, 1, 7, 32'h78);
        @(negedge clk);
        tick(); applyStimulus(1, instrF, 1, 0, 0, 0);
        @(negedge clk);
        tick(); applyStimulus(0, 32'h0, 1, 0, 0, 0);
        @(negedge clk);
        checkOutput("setwins F dst",  dif.dst,  15);
        checkOutput("setwins F src1", dif.src1, 32'h78);

        // Reset with a held bundle and busy bits outstanding.
        instrH = mkInstr(7'h52, 21, 8, 5, 0);
        tick(); applyStimulus(1, mkInstr(7'h51, 20, 21, 22, 0), 0, 0, 0, 0);
        @(negedge clk);
        tick(); applyStimulus(1, instrH, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("pre-reset held", dif.out_valid, 1);
        checkOutput("pre-reset stall", dif.in_ready, 0);
        tick(); rst = 1'b1;
        @(negedge clk);
        checkOutput("mid reset src1", dif.src1, 0);
        tick(); rst = 1'b0; applyStimulus(1, instrH, 1, 0, 0, 0);
        @(negedge clk);
        checkOutput("post-reset ready",     dif.in_ready,  1);
        checkOutput("post-reset out_valid", dif.out_valid, 0);
        tick(); applyStimulus(0, 32'h0, 1, 0, 0, 0);
        @(negedge clk);
        checkOutput("post-reset src1 reg8", dif.src1, 18);
        checkOutput("post-reset src2 reg5", dif.src2, 15);
        checkOutput("post-reset dst",       dif.dst,  21);
        tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
